// File: rtl/rd_stream_if.sv
// Read-side stream adapter: drains an async FIFO read port into a valid/ready stream
// through a two-entry head/skid buffer. Optional beat counter under RD_STREAM_BEAT_CNT_EN.
module rd_stream_if #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [31:0]      beat_cnt
);

  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} cnt_e;

  typedef struct packed {
    logic             last;
    logic [DSIZE-1:0] data;
  } ent_t;

  cnt_e          cnt_q, cnt_d;
  ent_t          head_q, head_d;
  ent_t          skid_q, skid_d;
  logic [PW-1:0] pidx_q, pidx_d;
  ent_t          in_ent;
  logic          push, pop, in_last;

  // Pop strobe looks only at registered occupancy, so m_ready never reaches rinc.
  assign push    = !rempty && (cnt_q != TWO);
  assign rinc    = push;
  assign m_valid = (cnt_q != EMPTY);
  assign pop     = m_valid && m_ready;
  assign m_data  = head_q.data;
  assign m_last  = head_q.last;

  assign in_last = (pidx_q == PW'(PKT_LEN - 1));
  assign in_ent  = {in_last, rdata};

  always_comb begin
    pidx_d = pidx_q;
    if (push) pidx_d = in_last ? '0 : pidx_q + 1'b1;
  end

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    case (cnt_q)
      EMPTY: if (push) begin
        head_d = in_ent;
        cnt_d  = ONE;
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_ent;
        end else if (push) begin
          skid_d = in_ent;
          cnt_d  = TWO;
        end else if (pop) begin
          cnt_d  = EMPTY;
        end
      end
      TWO: if (pop) begin
        head_d = skid_q;
        cnt_d  = ONE;
      end
      default: cnt_d = EMPTY;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
      pidx_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
      pidx_q <= pidx_d;
    end
  end

`ifdef RD_STREAM_BEAT_CNT_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)  beat_cnt_q <= '0;
    else if (pop) beat_cnt_q <= beat_cnt_q + 32'd1;
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: doc/rd_stream_if.md
# rd_stream_if

Read-side stream adapter placed directly downstream of the asynchronous FIFO in the `rclk` domain. It drains the FIFO through its `rempty`/`rinc`/`rdata` read port and presents the words as a valid/ready stream. A two-entry registered buffer gives full throughput without any combinational path from `m_ready` to `rinc`. Each outgoing word is tagged with a `m_last` flag every `PKT_LEN` beats.

## Interface
- `DSIZE`, 8, data width; must equal the FIFO's `DSIZE`.
- `PKT_LEN`, 4, beats per packet; legal range 1..256.
- `rclk` input 1: read-domain clock, shared with the FIFO read side.
- `rrst_n` input 1: reset; one clock, reset is asynchronous and active-low. Driven from the same net as the FIFO's `rrst_n`.
- `rdata` input `DSIZE`: FIFO head word; valid in the same cycle whenever `rempty`=0.
- `rempty` input 1: FIFO empty flag.
- `rinc` output 1: FIFO pop strobe; one word is consumed per `rclk` edge with `rinc`=1.
- `m_data` output `DSIZE`: stream data.
- `m_valid` output 1: stream valid.
- `m_ready` input 1: downstream accept.
- `m_last` output 1: marks the final beat of a packet.
- `beat_cnt` output 32: count of accepted beats (see Configuration).

## Operation
- **Buffer.** The adapter holds two entries, head and skid. Each entry stores {`last`, `data`}.
- **Occupancy state.** `cnt` takes the values EMPTY(0), ONE(1) and TWO(2).
- **Events.**
  - push = `rinc`
  - pop = `m_valid` & `m_ready`
- **Pop strobe.** `rinc` = !`rempty` & (`cnt` != TWO). It depends only on registered state and `rempty`, never on `m_ready`.
- **State transitions.**
  - EMPTY: push → ONE.
  - ONE: push & !pop → TWO; pop & !push → EMPTY; push & pop → ONE, and the head loads the new word.
  - TWO: pop → ONE, and the skid entry moves to the head. Push cannot occur in TWO.
- **Output mapping.**
  - `m_valid` = (`cnt` != EMPTY).
  - `m_data` and `m_last` always reflect the head entry.
  - The head stays stable while `m_valid`=1 and `m_ready`=0.
- **Packet index.** `pidx` is a counter of width clog2(`PKT_LEN`), with a minimum of 1 bit.
  - `pidx` increments on every push and wraps to 0 after `PKT_LEN`-1.
  - The pushed word's `last` = (`pidx` == `PKT_LEN`-1).
  - With `PKT_LEN`=1, every beat has `last`=1.
- **Ordering.** Words leave in FIFO order. No word is ever dropped or duplicated.
- **Reset mid-operation.** Buffered words are discarded and `pidx` returns to 0. The FIFO is reset by the same net, so the stream restarts clean.

## Timing
- **Reset values.**
  - `m_valid`=0, `m_data`=0, `m_last`=0, `beat_cnt`=0, `cnt`=EMPTY, `pidx`=0.
  - `rinc`=0 while `rempty`=1, which holds after the FIFO is reset.
- **Latency.** A word popped at edge N appears on `m_data` with `m_valid`=1 after edge N. This is one `rclk` of latency from `rinc` high to `m_valid`.
- **Throughput.** With `m_ready` held at 1 and the FIFO non-empty, the adapter sustains one beat per cycle in steady state ONE.
- **Back-pressure.**
  - With `m_ready`=0, at most two further words are popped, then `rinc`=0.
  - On `m_ready` rising, `rinc` reasserts in the first cycle in which `cnt` drops below TWO.
- **Simultaneous push and pop in ONE.** The head is replaced in the same edge, with no bubble.
- **Empty FIFO.** While `rempty`=1, `rinc` stays 0 regardless of state; the buffer drains normally.
- **Stream rule.** Once `m_valid` is asserted, it never deasserts before acceptance.

## Configuration
- Macro: `RD_STREAM_BEAT_CNT_EN`.
- **Defined.**
  - `beat_cnt` is a 32-bit register that increments on each pop (`m_valid` & `m_ready`).
  - It wraps from 0xFFFFFFFF to 0 and resets to 0.
- **Undefined.**
  - `beat_cnt` is tied to 0 and no counter logic is built.
  - All other behaviour is identical.

## Test plan
1. **Reset with empty FIFO.** Hold `rempty`=1 through reset → after reset `m_valid`=0, `m_data`=0, `m_last`=0 and `rinc`=0 for 20 cycles.
2. **Streaming.** Feed 0x01..0x08 with `m_ready`=1 → `rinc` high for 8 consecutive cycles; `m_data` shows 0x01..0x08 on consecutive cycles, starting 1 cycle after the first `rinc`; `m_last`=1 only on 0x04 and 0x08 (`PKT_LEN`=4).
3. **Back-pressure.** FIFO holds 0x10..0x15 and `m_ready`=0 → exactly two pops, then `rinc`=0 and `m_data` held at 0x10. Raise `m_ready` → 0x10..0x15 delivered in order with none lost.
4. **Throttled sink.** Toggle `m_ready` 1010… against a continuously non-empty FIFO → order preserved, no duplicates, and `cnt` never exceeds TWO.
5. **Reset mid-operation.** Assert `rrst_n` low while `cnt`=TWO mid-packet → `m_valid`=0 immediately (asynchronously). After release, the first new word has `pidx`=0 and `m_last` is set on the 4th beat.
6. **Beat counter.** With `RD_STREAM_BEAT_CNT_EN` defined, transfer 1000 beats → `beat_cnt`=1000. With the macro undefined → `beat_cnt`=0 throughout.
